// File: rtl/aes_decrypt_iter_if.sv
// aes_decrypt_iter_if: ciphertext-in / plaintext-out valid-ready bus for the iterative AES decryptor
interface aes_decrypt_iter_if #(parameter int NK = 4);
   logic [NK*32-1:0] key;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     ciphertext;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     plaintext;
   logic             busy;
   modport master (output key, in_valid, ciphertext, out_ready,
                   input  in_ready, out_valid, plaintext, busy);
   modport slave  (input  key, in_valid, ciphertext, out_ready,
                   output in_ready, out_valid, plaintext, busy);
endinterface

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES inverse cipher, one round per clock, valid/ready on both sides
module aes_decrypt_iter #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input logic             clk,
   input logic             rst_n,
   aes_decrypt_iter_if.slave bus
);
   localparam int RW = $clog2(NR + 1);
   localparam int KW = (NR + 1) * 128;
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   // The inverse table is derived at elaboration so it can never drift from SBOX.
   function automatic logic [0:2047] f_inv_tab(input logic [0:2047] s);
      logic [0:2047] r;
      r = '0;
      for (int i = 0; i < 256; i++) r[int'(s[i*8 +: 8])*8 +: 8] = 8'(i);
      return r;
   endfunction
   localparam logic [0:2047] ISBOX = f_inv_tab(SBOX);
   function automatic logic [7:0] f_sb(input logic [7:0] b);
      return SBOX[int'(b)*8 +: 8];
   endfunction
   function automatic logic [7:0] f_isb(input logic [7:0] b);
      return ISBOX[int'(b)*8 +: 8];
   endfunction
   function automatic logic [7:0] f_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = f_xt(x);
      end
      return r;
   endfunction
   function automatic logic [31:0] f_subw(input logic [31:0] t);
      return {f_sb(t[31:24]), f_sb(t[23:16]), f_sb(t[15:8]), f_sb(t[7:0])};
   endfunction
   // Round key k occupies bits [k*128 +: 128] of the ascending-indexed schedule.
   function automatic logic [0:KW-1] f_expand(input logic [NK*32-1:0] k);
      logic [31:0]   w [0:4*NR+3];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:KW-1] r;
      rc = 8'h01;
      r  = '0;
      for (int i = 0; i < 4*NR+4; i++) begin
         if (i < NK) w[i] = k[(NK-1-i)*32 +: 32];
         else begin
            t = w[i-1];
            if (i % NK == 0) begin
               t  = f_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = f_xt(rc);
            end else if (NK > 6 && i % NK == 4) t = f_subw(t);
            w[i] = w[i-NK] ^ t;
         end
         r[i*32 +: 32] = w[i];
      end
      return r;
   endfunction
   function automatic logic [127:0] f_isr_isb(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int j = 0; j < 4; j++)
            r[127-8*(4*c+j) -: 8] = f_isb(s[127-8*(4*((c-j+4)%4)+j) -: 8]);
      return r;
   endfunction
   function automatic logic [127:0] f_imix(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int j = 0; j < 4; j++)
            r[127-8*(4*c+j) -: 8] = f_gmul(s[127-8*(4*c+j)       -: 8], 8'h0e)
                                  ^ f_gmul(s[127-8*(4*c+(j+1)%4) -: 8], 8'h0b)
                                  ^ f_gmul(s[127-8*(4*c+(j+2)%4) -: 8], 8'h0d)
                                  ^ f_gmul(s[127-8*(4*c+(j+3)%4) -: 8], 8'h09);
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
   fsm_t             r_fsm;
   logic [NK*32-1:0] r_key;
   logic [127:0]     r_state;
   logic [RW-1:0]    r_rnd;
   logic [127:0]     r_pt;
   logic             r_ov;
   logic [0:KW-1]    w_sched;
   logic [RW-1:0]    w_idx;
   logic [127:0]     w_rk;
   logic [127:0]     w_ark;

   // In IDLE the schedule comes from the port key so the whitening key is ready at the handshake.
   assign w_sched = f_expand(r_fsm == IDLE ? bus.key : r_key);
   assign w_idx   = r_fsm == IDLE ? RW'(NR) : r_fsm == FINAL ? '0 : r_rnd;
   assign w_rk    = w_sched[int'(w_idx)*128 +: 128];
   assign w_ark   = f_isr_isb(r_state) ^ w_rk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm   <= IDLE;
         r_key   <= '0;
         r_state <= '0;
         r_rnd   <= '0;
         r_pt    <= '0;
         r_ov    <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: if (bus.in_valid) begin
               r_key   <= bus.key;
               r_state <= bus.ciphertext ^ w_rk;
               r_rnd   <= RW'(NR - 1);
               r_fsm   <= ROUND;
            end
            ROUND: begin
               r_state <= f_imix(w_ark);
               if (r_rnd == RW'(1)) r_fsm <= FINAL;
               else r_rnd <= r_rnd - RW'(1);
            end
            FINAL: begin
               r_pt  <= w_ark;
               r_ov  <= 1'b1;
               r_fsm <= DONE;
            end
            DONE: if (bus.out_ready) begin
               r_ov  <= 1'b0;
               r_fsm <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_fsm == IDLE;
   assign bus.out_valid = r_ov;
   assign bus.plaintext = r_pt;
   assign bus.busy      = r_fsm == ROUND || r_fsm == FINAL;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter: directed FIPS-197 vectors for AES-128/192/256 decryption with handshake,
// backpressure, input isolation and mid-operation reset
module tb_aes_decrypt_iter;
   localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] k;
   logic [127:0] ct;
   logic         iv, ordy;
   int           sel;
   int           n_chk = 0, n_fail = 0;
   logic [127:0] pt;
   logic         ov, ir, bsy;

   always #5 clk = ~clk;

   aes_decrypt_iter_if #(.NK(4)) b4();
   aes_decrypt_iter_if #(.NK(6)) b6();
   aes_decrypt_iter_if #(.NK(8)) b8();

   // The 128/192-bit test keys are the leading bytes of the 256-bit one.
   assign b4.key = k[255:128];
   assign b6.key = k[255:64];
   assign b8.key = k;
   assign b4.ciphertext = ct;
   assign b6.ciphertext = ct;
   assign b8.ciphertext = ct;
   assign b4.in_valid = iv && sel == 0;
   assign b6.in_valid = iv && sel == 1;
   assign b8.in_valid = iv && sel == 2;
   assign b4.out_ready = ordy;
   assign b6.out_ready = ordy;
   assign b8.out_ready = ordy;

   assign pt  = sel == 0 ? b4.plaintext : sel == 1 ? b6.plaintext : b8.plaintext;
   assign ov  = sel == 0 ? b4.out_valid : sel == 1 ? b6.out_valid : b8.out_valid;
   assign ir  = sel == 0 ? b4.in_ready  : sel == 1 ? b6.in_ready  : b8.in_ready;
   assign bsy = sel == 0 ? b4.busy      : sel == 1 ? b6.busy      : b8.busy;

   aes_decrypt_iter #(.NK(4), .NR(10)) u128 (.clk(clk), .rst_n(rst_n), .bus(b4));
   aes_decrypt_iter #(.NK(6), .NR(12)) u192 (.clk(clk), .rst_n(rst_n), .bus(b6));
   aes_decrypt_iter #(.NK(8), .NR(14)) u256 (.clk(clk), .rst_n(rst_n), .bus(b8));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input int s, input logic [127:0] c, input int lat, input string tag);
      int n;
      sel = s;
      k   = KEY;
      ct  = c;
      iv  = 1'b1;
      #1;
      chk({tag, " in_ready"}, 128'(ir), 128'(1));
      @(posedge clk); #1;
      iv = 1'b0;
      k  = '1;
      ct = '1;
      chk({tag, " busy"}, 128'(bsy), 128'(1));
      chk({tag, " in_ready low"}, 128'(ir), 128'(0));
      n = 0;
      while (!ov && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 128'(n), 128'(lat));
      chk({tag, " plaintext"}, pt, PT);
      chk({tag, " busy in done"}, 128'(bsy), 128'(0));
   endtask

   task automatic consume(input string tag);
      @(posedge clk); #1;
      chk({tag, " out_valid drop"}, 128'(ov), 128'(0));
      chk({tag, " in_ready back"}, 128'(ir), 128'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      iv = 1'b0; ordy = 1'b1; sel = 0; k = '0; ct = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("reset out_valid", 128'(ov), 128'(0));
         chk("reset plaintext", pt, 128'(0));
         chk("reset busy", 128'(bsy), 128'(0));
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", 128'(ir), 128'(1));

      ordy = 1'b0;
      run(0, C128, 10, "aes128 stall");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("stall plaintext", pt, PT);
         chk("stall out_valid", 128'(ov), 128'(1));
         chk("stall in_ready", 128'(ir), 128'(0));
      end
      ordy = 1'b1;
      consume("aes128 stall");

      run(0, C128, 10, "aes128 second");
      consume("aes128 second");
      run(1, C192, 12, "aes192");
      consume("aes192");
      run(2, C256, 14, "aes256");
      consume("aes256");

      sel = 0; k = KEY; ct = C128; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 128'(ov), 128'(0));
      chk("midreset plaintext", pt, 128'(0));
      chk("midreset busy", 128'(bsy), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset in_ready", 128'(ir), 128'(1));
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ov) seen++;
      end
      chk("midreset no spurious out_valid", 128'(seen), 128'(0));
      run(0, C128, 10, "aes128 after reset");
      consume("aes128 after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES inverse cipher (FIPS-197 §5.3): one 128-bit ciphertext block in, one plaintext block out.
- This is the decrypt side of the team's iterative encrypt datapath. It processes one round per clock.
- It reuses the existing keyExpansion module (same NK/NR parameters and word ordering) and adds a valid/ready handshake on both sides.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8 = AES-128/192/256).
- NR, 10, number of rounds. Must pair with NK as 10/12/14; other pairings are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key  input  NK*32  cipher key, sampled only on input handshake.
- in_valid  input  1  ciphertext/key valid.
- in_ready  output  1  block can accept a new ciphertext.
- ciphertext  input  128  ciphertext block, MSB = byte 0.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts plaintext.
- plaintext  output  128  decrypted block, MSB = byte 0.
- busy  output  1  high in LOAD-complete/ROUND/FINAL work (state != IDLE and != DONE).

Behaviour:
- Reset (async, rst_n=0): fsm=IDLE, state reg=0, key reg=0, round counter=0, plaintext=0, out_valid=0, busy=0; in_ready=1 once rst_n is high.
- Key register feeds keyExpansion. Round key k is w[k*128 +: 128], with w indexed [0:(NR+1)*128-1], so round key 0 = w[0:127].
- FSM states: IDLE, ROUND, FINAL, DONE.
- in_ready = (fsm==IDLE). in_valid is ignored in every other state.
- IDLE, on in_valid&in_ready at edge E:
  - key reg <= key.
  - state <= ciphertext ^ RK(NR), computed from key directly (expansion of the port value, not the stale register).
  - rnd <= NR-1.
  - fsm <= ROUND. If NR==1 is requested, it is unsupported.
- ROUND, each edge: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), RK(rnd))).
  - If rnd==1: fsm <= FINAL.
  - Otherwise rnd <= rnd-1.
  - NR-1 ROUND edges total: E+1 .. E+NR-1.
- FINAL, edge E+NR:
  - plaintext <= AddRoundKey(InvSubBytes(InvShiftRows(state)), RK(0)).
  - out_valid <= 1; fsm <= DONE.
- DONE:
  - plaintext and out_valid are held stable until out_valid&out_ready.
  - On that edge: out_valid <= 0, fsm <= IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.
- Latency: out_valid is visible after edge E+NR (10/12/14 cycles for AES-128/192/256). Throughput is one block per NR+2 cycles with out_ready held high.
- Changes on key/ciphertext after acceptance have no effect on the block in flight.
- rst_n asserted mid-operation: result is discarded, all state goes to reset values immediately, and no out_valid pulse occurs.
- out_ready held high before DONE has no effect. out_ready low in DONE stalls indefinitely with outputs constant.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e,0b,0d,09.
- The inverse S-box is an internal combinational table.
- No X-checks on inputs; behaviour is defined only by the handshake.

Test Plan:
- AES-128 (NK=4,NR=10), key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid rises exactly 10 edges after handshake.
- AES-192 (NK=6,NR=12), key 000102…1617, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 -> plaintext 00112233445566778899aabbccddeeff at 12 edges.
- AES-256 (NK=8,NR=14), key 000102…1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff at 14 edges.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid -> plaintext/out_valid stable and in_ready=0.
  - Then pulse out_ready -> out_valid=0 next cycle, in_ready=1.
  - A second block is accepted and decrypts correctly.
- Input isolation: after handshake, drive key and ciphertext to all-ones -> AES-128 result is still 00112233445566778899aabbccddeeff.
- Reset mid-round: drop rst_n at edge E+5 -> out_valid=0, plaintext=0, in_ready=1 after release, no spurious out_valid. A new block then decrypts correctly.
